// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, instruction field positions
// and small opcode-classification helpers used by the decode stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int OPC_W     = 6;
  localparam int REG_W     = 5;
  localparam int IMM_W     = 16;

  typedef enum logic [1:0] {
    FMT_R     = 2'd0,
    FMT_LOAD  = 2'd1,
    FMT_STORE = 2'd2,
    FMT_I     = 2'd3
  } insn_fmt_t;

  function automatic insn_fmt_t fmt_of(input logic [5:0] op);
    insn_fmt_t f;
    if (op == OP_RTYPE)   f = FMT_R;
    else if (op == OP_LW) f = FMT_LOAD;
    else if (op == OP_SW) f = FMT_STORE;
    else                  f = FMT_I;
    return f;
  endfunction

  // Logical immediates take their 16 bits unsigned; everything else sign-extends.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/regfile_mp.sv
// XLEN x NREGS register file, two combinational read ports and one write port.
// Write-through bypass on the read ports is enabled by defining DECODE_WB_BYPASS_EN.
module regfile_mp
  import mips_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  // A same-cycle write to the addressed register is visible immediately.
  assign ra_data = (ra_addr == '0) ? '0 :
                   (wr_en && (wr_addr == ra_addr)) ? wr_data : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 :
                   (wr_en && (wr_addr == rb_addr)) ? wr_data : mem[rb_addr];
`else
  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];
`endif

endmodule

// File: rtl/decode_stage.sv
// Pipelined MIPS decode: field split, register read, immediate extension and
// the ID/EX register with valid/ready handshakes and a load-use interlock.
// Optional write-through bypass in the register file: DECODE_WB_BYPASS_EN.
module decode_stage
  import mips_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      opcode,
  output logic [5:0]      funct,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic [XLEN-1:0] signex,
  output logic [AW-1:0]   rt,
  output logic [AW-1:0]   rd
);

  function automatic logic signed [XLEN-1:0] ext_imm(input logic [5:0] op,
                                                     input logic signed [IMM_W-1:0] imm);
    logic signed [XLEN-1:0] r;
    if (is_zext_op(op)) r = {{(XLEN-IMM_W){1'b0}}, imm};
    else                r = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    return r;
  endfunction

  logic [OPC_W-1:0]        opc_in;
  logic [5:0]              funct_in;
  logic [REG_W-1:0]        rs_f, rt_f, rd_f;
  logic signed [IMM_W-1:0] imm_in;
  logic [AW-1:0]           rs_in, rt_in, rd_in;
  logic [XLEN-1:0]         rs_val, rt_val;

  assign opc_in   = instruction[OPC_LSB +: OPC_W];
  assign funct_in = instruction[FUNCT_LSB +: 6];
  assign rs_f     = instruction[RS_LSB +: REG_W];
  assign rt_f     = instruction[RT_LSB +: REG_W];
  assign rd_f     = instruction[RD_LSB +: REG_W];
  assign imm_in   = instruction[IMM_LSB +: IMM_W];

  // Register indices wider than the file alias modulo NREGS.
  assign rs_in = rs_f[AW-1:0];
  assign rt_in = rt_f[AW-1:0];
  assign rd_in = rd_f[AW-1:0];

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .ra_addr (rs_in),
    .ra_data (rs_val),
    .rb_addr (rt_in),
    .rb_data (rt_val),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data)
  );

  logic                   vld_p1;
  logic [5:0]             opcode_p1, funct_p1;
  logic [XLEN-1:0]        data1_p1, data2_p1;
  logic signed [XLEN-1:0] signex_p1;
  logic [AW-1:0]          rt_p1, rd_p1;

  logic advance, hazard, accept;

  // A load in ID/EX whose destination feeds the incoming instruction forces one bubble.
  assign hazard  = vld_p1 && (fmt_of(opcode_p1) == FMT_LOAD) && (rt_p1 != '0) &&
                   ((rt_p1 == rs_in) || (rt_p1 == rt_in));
  assign advance = out_ready || !vld_p1;
  assign in_ready = advance && !hazard;
  assign accept  = in_valid && in_ready;

  // ---- stage p1: ID/EX register ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      opcode_p1 <= '0;
      funct_p1  <= '0;
      data1_p1  <= '0;
      data2_p1  <= '0;
      signex_p1 <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
    end else if (advance) begin
      vld_p1 <= accept;
      if (accept) begin
        opcode_p1 <= opc_in;
        funct_p1  <= funct_in;
        data1_p1  <= rs_val;
        data2_p1  <= rt_val;
        signex_p1 <= ext_imm(opc_in, imm_in);
        rt_p1     <= rt_in;
        rd_p1     <= rd_in;
      end
    end
  end

  assign out_valid = vld_p1;
  assign opcode    = opcode_p1;
  assign funct     = funct_p1;
  assign data1     = data1_p1;
  assign data2     = data2_p1;
  assign signex    = signex_p1;
  assign rt        = rt_p1;
  assign rd        = rd_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode/extension plus
// hand sequences for reset, load-use, bypass and backpressure.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] signex;
  logic [4:0]  rt;
  logic [4:0]  rd;

  int checks   = 0;
  int failures = 0;

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opcode      (opcode),
    .funct       (funct),
    .data1       (data1),
    .data2       (data2),
    .signex      (signex),
    .rt          (rt),
    .rd          (rd)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] sx;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } vec_t;

  vec_t vt [8];

  function automatic logic [31:0] rtype(input logic [4:0] rs_i, input logic [4:0] rt_i,
                                        input logic [4:0] rd_i, input logic [5:0] fn_i);
    return {6'h00, rs_i, rt_i, rd_i, 5'd0, fn_i};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op_i, input logic [4:0] rs_i,
                                        input logic [4:0] rt_i, input logic [15:0] imm_i);
    return {op_i, rs_i, rt_i, imm_i};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    @(posedge clock);
    #1;
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins);
    @(negedge clock);
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    instruction = ins;
  endtask

  logic [31:0] bypass_exp;

  initial begin
    vt[0] = '{rtype(5'd5, 5'd0, 5'd3, 6'h20),           32'hDEADBEEF, 32'h0,        32'h00001820, 6'h00, 6'h20, 5'd0,  5'd3};
    vt[1] = '{itype(6'h08, 5'd1, 5'd2, 16'h8001),       32'h11111111, 32'h22222222, 32'hFFFF8001, 6'h08, 6'h01, 5'd2,  5'd16};
    vt[2] = '{itype(6'h0D, 5'd2, 5'd1, 16'h8001),       32'h22222222, 32'h11111111, 32'h00008001, 6'h0D, 6'h01, 5'd1,  5'd16};
    vt[3] = '{itype(6'h0C, 5'd0, 5'd5, 16'hFFFF),       32'h0,        32'hDEADBEEF, 32'h0000FFFF, 6'h0C, 6'h3F, 5'd5,  5'd31};
    vt[4] = '{itype(6'h0E, 5'd9, 5'd31, 16'h7FFF),      32'hAAAA0000, 32'h80000000, 32'h00007FFF, 6'h0E, 6'h3F, 5'd31, 5'd15};
    vt[5] = '{itype(6'h2B, 5'd31, 5'd9, 16'hFFFE),      32'h80000000, 32'hAAAA0000, 32'hFFFFFFFE, 6'h2B, 6'h3E, 5'd9,  5'd31};
    vt[6] = '{itype(6'h23, 5'd1, 5'd0, 16'h0004),       32'h11111111, 32'h0,        32'h00000004, 6'h23, 6'h04, 5'd0,  5'd0};
    vt[7] = '{rtype(5'd0, 5'd0, 5'd0, 6'h20),           32'h0,        32'h0,        32'h00000020, 6'h00, 6'h20, 5'd0,  5'd0};

`ifdef DECODE_WB_BYPASS_EN
    bypass_exp = 32'h12345678;
`else
    bypass_exp = 32'hAAAA0000;
`endif

    reset = 1'b1; in_valid = 1'b0; instruction = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_data1", data1, 32'd0);
    chk("reset_signex", signex, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    wb_write(5'd0,  32'hFFFFFFFF);
    wb_write(5'd1,  32'h11111111);
    wb_write(5'd2,  32'h22222222);
    wb_write(5'd5,  32'hDEADBEEF);
    wb_write(5'd9,  32'hAAAA0000);
    wb_write(5'd31, 32'h80000000);

    for (int i = 0; i < 8; i++) begin
      issue(vt[i].instr);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vt[i].op));
      chk($sformatf("v%0d_funct", i), 32'(funct), 32'(vt[i].fn));
      chk($sformatf("v%0d_data1", i), data1, vt[i].d1);
      chk($sformatf("v%0d_data2", i), data2, vt[i].d2);
      chk($sformatf("v%0d_signex", i), signex, vt[i].sx);
      chk($sformatf("v%0d_rt", i), 32'(rt), 32'(vt[i].rt));
      chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vt[i].rd));
    end

    // load-use on rs: LW r7 then ADD rs=7
    issue(itype(6'h23, 5'd0, 5'd7, 16'h0000));
    @(posedge clock); #1;
    chk("lu_lw_opcode", 32'(opcode), 32'h23);
    issue(rtype(5'd7, 5'd0, 5'd4, 6'h20));
    #1;
    chk("lu_stall_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    chk("lu_bubble", 32'(out_valid), 32'd0);
    @(negedge clock); #1;
    chk("lu_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    chk("lu_add_valid", 32'(out_valid), 32'd1);
    chk("lu_add_rd", 32'(rd), 32'd4);
    chk("lu_add_opcode", 32'(opcode), 32'h00);

    // load-use on rt: LW r3 then ORI rt=3
    issue(itype(6'h23, 5'd0, 5'd3, 16'h0000));
    @(posedge clock); #1;
    issue(itype(6'h0D, 5'd0, 5'd3, 16'h0001));
    #1;
    chk("lu_rt_stall", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    chk("lu_rt_bubble", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    chk("lu_rt_ori", 32'(opcode), 32'h0D);

    // same-cycle writeback vs read
    issue(rtype(5'd9, 5'd0, 5'd8, 6'h20));
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h12345678;
    @(posedge clock); #1;
    wb_en = 1'b0;
    chk("bypass_data1", data1, bypass_exp);
    issue(rtype(5'd9, 5'd0, 5'd8, 6'h20));
    @(posedge clock); #1;
    chk("bypass_after_data1", data1, 32'h12345678);

    // backpressure: 3 stalled cycles with a write to the held rs register
    issue(rtype(5'd1, 5'd2, 5'd6, 6'h20));
    @(posedge clock); #1;
    chk("bp_first_rd", 32'(rd), 32'd6);
    @(negedge clock);
    out_ready = 1'b0;
    instruction = itype(6'h0D, 5'd2, 5'd3, 16'h1234);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55555555;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      @(posedge clock); #1;
      wb_en = 1'b0;
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_rd", k), 32'(rd), 32'd6);
      chk($sformatf("bp%0d_data1", k), data1, 32'h11111111);
      chk($sformatf("bp%0d_data2", k), data2, 32'h22222222);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    chk("bp_ori_opcode", 32'(opcode), 32'h0D);
    chk("bp_ori_signex", signex, 32'h00001234);
    chk("bp_ori_rt", 32'(rt), 32'd3);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock); #1;
    chk("bp_no_duplicate", 32'(out_valid), 32'd0);

    // reset mid-stream
    issue(rtype(5'd5, 5'd0, 5'd3, 6'h20));
    @(posedge clock); #1;
    chk("mid_valid_before", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_data1", data1, 32'd0);
    chk("mid_opcode", 32'(opcode), 32'd0);
    chk("mid_funct", 32'(funct), 32'd0);
    chk("mid_rd", 32'(rd), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    issue(rtype(5'd5, 5'd0, 5'd3, 6'h20));
    @(posedge clock); #1;
    chk("mid_r5_cleared", data1, 32'd0);
    chk("mid_valid_after", 32'(out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
